mem_readback_checker: RTL and testbench

- Read-side counterpart of the memory write sequencer: sweeps a memory read port over a programmable address range and compares each word against an expected incrementing pattern (expected = seed + address).
- Reports pass/fail, a saturating error count and the first failing address.
- Sits beside the RAMMEM/MRMWMEM primitives in memory test harnesses and drives one read port.

---
 rtl/mem_readback_checker.sv | 140 ++++++++++++++
 tb/tb_mem_readback_checker.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_readback_checker.sv
// Sweeps a memory read port over [0, count) and checks each word against seed + address.
// Reports pass/fail, a saturating error count and the first failing address.
module mem_readback_checker #(
  parameter int DEPTH        = 32,
  parameter int ADDR_BITS    = 5,
  parameter int WIDTH        = 32,
  parameter int READ_LATENCY = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     seed,
  input  logic [ADDR_BITS:0]   count,
  output logic                 rd_en,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [WIDTH-1:0]     rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_count,
  output logic                 first_err_valid,
  output logic [ADDR_BITS-1:0] first_err_addr
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS+1)'(DEPTH);

  state_t               state;
  logic [WIDTH-1:0]     seed_r;
  logic [ADDR_BITS-1:0] last_addr;
  logic                 p_valid;
  logic [ADDR_BITS-1:0] p_addr;
  logic [WIDTH-1:0]     p_exp;

  logic [ADDR_BITS:0]   count_clamp;
  logic                 cmp_valid;
  logic [ADDR_BITS-1:0] cmp_addr;
  logic [WIDTH-1:0]     cmp_exp;
  logic                 mismatch;

  // With a registered memory the compare runs one cycle behind the issued address.
  always_comb begin
    count_clamp = (count > DEPTH_W) ? DEPTH_W : count;
    cmp_valid   = 1'b0;
    cmp_addr    = '0;
    cmp_exp     = '0;
    if (READ_LATENCY == 0) begin
      cmp_valid = (state == SCAN);
      cmp_addr  = rd_addr;
      cmp_exp   = seed_r + WIDTH'(rd_addr);
    end else begin
      cmp_valid = p_valid;
      cmp_addr  = p_addr;
      cmp_exp   = p_exp;
    end
    mismatch = cmp_valid && (rd_data != cmp_exp);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      seed_r          <= '0;
      last_addr       <= '0;
      p_valid         <= 1'b0;
      p_addr          <= '0;
      p_exp           <= '0;
      rd_en           <= 1'b0;
      rd_addr         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
    end else begin
      done    <= 1'b0;
      p_valid <= 1'b0;

      if (mismatch) begin
        if (err_count != '1)
          err_count <= err_count + 16'd1;
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_addr  <= cmp_addr;
        end
      end

      case (state)
        IDLE: begin
          rd_addr <= '0;
          if (start) begin
            seed_r          <= seed;
            last_addr       <= ADDR_BITS'(count_clamp - 1'b1);
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            pass            <= 1'b0;
            busy            <= 1'b1;
            if (count_clamp == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SCAN;
              rd_en <= 1'b1;
            end
          end
        end
        SCAN: begin
          p_valid <= (READ_LATENCY != 0);
          p_addr  <= rd_addr;
          p_exp   <= seed_r + WIDTH'(rd_addr);
          if (rd_addr == last_addr) begin
            rd_en <= 1'b0;
            if (READ_LATENCY == 0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          pass    <= (err_count == '0);
          rd_addr <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_readback_checker.sv
// Directed bench for mem_readback_checker: one combinational-read and one registered-read
// instance, each with its own memory model; scan results go through a scoreboard queue.
module tb_mem_readback_checker;

  logic        clock = 1'b0;
  logic        reset;
  logic        start0, start1;
  logic [31:0] seed;
  logic [5:0]  count;

  logic        rd_en0, rd_en1, busy0, busy1, done0, done1, pass0, pass1, fev0, fev1;
  logic [4:0]  rd_addr0, rd_addr1, fea0, fea1;
  logic [15:0] err0, err1;
  logic [31:0] rd_data0, rd_data1;

  logic [31:0] mem0 [32];
  logic [31:0] mem1 [32];

  typedef struct {
    logic        pass;
    logic [15:0] errs;
    logic        fev;
    logic [4:0]  fea;
    int          lat;
    int          last;
    int          n_en;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  assign rd_data0 = mem0[rd_addr0];
  always_ff @(posedge clock) if (rd_en1) rd_data1 <= mem1[rd_addr1];

  mem_readback_checker #(.DEPTH(32), .ADDR_BITS(5), .WIDTH(32), .READ_LATENCY(0)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .seed(seed), .count(count),
    .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0), .first_err_valid(fev0), .first_err_addr(fea0));

  mem_readback_checker #(.DEPTH(32), .ADDR_BITS(5), .WIDTH(32), .READ_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .seed(seed), .count(count),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .first_err_valid(fev1), .first_err_addr(fea1));

  function automatic logic f_en(bit rl);     return rl ? rd_en1 : rd_en0;     endfunction
  function automatic logic [4:0] f_addr(bit rl); return rl ? rd_addr1 : rd_addr0; endfunction
  function automatic logic f_busy(bit rl);   return rl ? busy1 : busy0;       endfunction
  function automatic logic f_done(bit rl);   return rl ? done1 : done0;       endfunction
  function automatic logic f_pass(bit rl);   return rl ? pass1 : pass0;       endfunction
  function automatic logic [15:0] f_err(bit rl); return rl ? err1 : err0;     endfunction
  function automatic logic f_fev(bit rl);    return rl ? fev1 : fev0;         endfunction
  function automatic logic [4:0] f_fea(bit rl);  return rl ? fea1 : fea0;     endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input bit rl, input string tag);
    chk({tag, "_outputs"},
        {14'(0), f_en(rl), f_addr(rl), f_busy(rl), f_done(rl), f_pass(rl), f_fev(rl), f_fea(rl)}
          | {16'(0), f_err(rl)}, 32'h0);
  endtask

  // Drives one scan, pushes the model's expected result, pops it when done is seen.
  task automatic do_scan(input bit rl, input logic [31:0] sd, input logic [5:0] cnt, input bit poke);
    exp_t e, g;
    int clamp, cyc, max_a, n_en;
    bit bad_drain;
    clamp = (cnt > 6'd32) ? 32 : int'(cnt);
    e.errs = '0; e.fev = 1'b0; e.fea = '0;
    for (int a = 0; a < clamp; a++) begin
      logic [31:0] w;
      w = rl ? mem1[a] : mem0[a];
      if (w !== sd + 32'(a)) begin
        if (!e.fev) begin e.fev = 1'b1; e.fea = 5'(a); end
        e.errs++;
      end
    end
    e.pass = (e.errs == 0);
    e.lat  = (clamp == 0) ? 1 : clamp + 1 + int'(rl);
    e.last = (clamp == 0) ? 0 : clamp - 1;
    e.n_en = clamp;
    sb.push_back(e);

    @(negedge clock);
    seed = sd; count = cnt; start0 = !rl; start1 = rl;
    @(negedge clock);
    start0 = 1'b0; start1 = 1'b0;
    cyc = 1; max_a = 0; n_en = 0; bad_drain = 1'b0;
    chk("cleared_on_start", {15'(0), f_fev(rl), f_err(rl)}, 32'h0);
    while (!f_done(rl) && cyc < 100) begin
      if (f_en(rl)) begin
        n_en++;
        if (int'(f_addr(rl)) > max_a) max_a = int'(f_addr(rl));
      end
      if (rl && clamp > 0 && cyc == clamp + 1 && f_en(rl)) bad_drain = 1'b1;
      if (poke && cyc == 3) begin start0 = !rl; start1 = rl; end
      else begin start0 = 1'b0; start1 = 1'b0; end
      @(negedge clock);
      cyc++;
    end
    g = sb.pop_front();
    chk("done_seen", 32'(f_done(rl)), 32'h1);
    chk("latency", 32'(cyc), 32'(g.lat));
    chk("rd_en_cycles", 32'(n_en), 32'(g.n_en));
    chk("last_addr", 32'(max_a), 32'(g.last));
    chk("no_rd_en_drain", 32'(bad_drain), 32'h0);
    chk("done_busy", 32'(f_busy(rl)), 32'h1);
    chk("err_count", 32'(f_err(rl)), 32'(g.errs));
    chk("first_err_valid", 32'(f_fev(rl)), 32'(g.fev));
    chk("first_err_addr", 32'(f_fea(rl)), 32'(g.fea));
    if (poke) begin start0 = !rl; start1 = rl; end
    @(negedge clock);
    start0 = 1'b0; start1 = 1'b0;
    chk("done_one_cycle", 32'(f_done(rl)), 32'h0);
    chk("idle_busy", 32'(f_busy(rl)), 32'h0);
    chk("pass", 32'(f_pass(rl)), 32'(g.pass));
    chk("idle_rd_addr", 32'(f_addr(rl)), 32'h0);
  endtask

  initial begin
    int guard, done_hits;
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; seed = '0; count = '0;
    for (int a = 0; a < 32; a++) begin
      mem0[a] = 32'd100 + 32'(a);
      mem1[a] = 32'h0;
    end
    mem1[0] = 32'hFFFF_FFFE; mem1[1] = 32'hFFFF_FFFF; mem1[2] = 32'h0; mem1[3] = 32'h1;
    repeat (2) @(negedge clock);
    chk_all_zero(1'b0, "reset0");
    chk_all_zero(1'b1, "reset1");
    reset = 1'b0;

    do_scan(1'b0, 32'd100, 6'd32, 1'b0);
    mem0[7] = 32'h0; mem0[20] = 32'd5;
    do_scan(1'b0, 32'd100, 6'd32, 1'b1);
    do_scan(1'b0, 32'd100, 6'd32, 1'b0);
    mem0[7] = 32'd107; mem0[20] = 32'd120;
    do_scan(1'b0, 32'd100, 6'd40, 1'b0);
    do_scan(1'b0, 32'd100, 6'd0, 1'b0);
    do_scan(1'b1, 32'd7, 6'd0, 1'b0);
    do_scan(1'b1, 32'hFFFF_FFFE, 6'd4, 1'b0);
    mem1[3] = 32'd9;
    do_scan(1'b1, 32'hFFFF_FFFE, 6'd4, 1'b1);
    mem1[3] = 32'h1;
    do_scan(1'b1, 32'hFFFF_FFFE, 6'd4, 1'b0);

    // Abort a scan with reset while rd_addr is 10; an error at word 7 is already counted.
    mem0[7] = 32'h0;
    @(negedge clock);
    seed = 32'd100; count = 6'd32; start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    guard = 0;
    while (rd_addr0 != 5'd10 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    chk("reached_addr10", 32'(rd_addr0), 32'd10);
    chk("err_before_reset", 32'(err0), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk_all_zero(1'b0, "midscan_reset");
    done_hits = 0;
    repeat (40) begin
      @(negedge clock);
      if (done0) done_hits++;
    end
    chk("no_done_after_abort", 32'(done_hits), 32'h0);
    mem0[7] = 32'd107;
    do_scan(1'b0, 32'd100, 6'd32, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
